ringosc_meter: RTL and testbench



---
 rtl/ringosc_pkg.sv | 20 ++
 rtl/osc_edge_sync.sv | 33 +++
 rtl/ringosc_meter.sv | 145 ++++++++++++++
 tb/tb_ringosc_meter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ringosc_pkg.sv
// rtl/ringosc_pkg.sv - shared types and default constants for the ring oscillator meter
package ringosc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meter_state_t;

  localparam int CNT_W_DEF      = 16;
  localparam int GATE_W_DEF     = 16;
  localparam int SETTLE_CYC_DEF = 8;

  // Width of a down-counter that is loaded with n-1 and runs to zero.
  function automatic int settle_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - 2-FF synchronizer plus history register and rising-edge pulse
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = osc_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/ringosc_meter.sv
// rtl/ringosc_meter.sv - ring oscillator frequency meter: enable, settle, gated edge count
module ringosc_meter
  import ringosc_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int GATE_W     = GATE_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic              osc_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int SETTLE_W = settle_cnt_width(SETTLE_CYC);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

  logic edge_pulse;

  meter_state_t        state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                osc_en_q, osc_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT_W-1:0]    acc_inc;
  logic                acc_ovf_inc;

  osc_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .osc_in     (osc_in),
    .edge_pulse (edge_pulse)
  );

  // Saturating accumulate; the sticky flag records any increment attempted at all-ones.
  always_comb begin
    acc_inc     = acc_q;
    acc_ovf_inc = acc_ovf_q;
    if (edge_pulse) begin
      if (&acc_q) acc_ovf_inc = 1'b1;
      else        acc_inc     = acc_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    acc_d        = acc_q;
    acc_ovf_d    = acc_ovf_q;
    count_d      = count_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          gate_cnt_d   = gate_cycles;
          acc_d        = '0;
          acc_ovf_d    = 1'b0;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          if (gate_cnt_q == '0) begin
            count_d    = acc_q;
            overflow_d = acc_ovf_q;
            state_d    = DONE;
          end else begin
            state_d = MEASURE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      MEASURE: begin
        acc_d      = acc_inc;
        acc_ovf_d  = acc_ovf_inc;
        gate_cnt_d = gate_cnt_q - GATE_W'(1);
        // The last gate cycle's edge is folded straight into the loaded result.
        if (gate_cnt_q == GATE_W'(1)) begin
          count_d    = acc_inc;
          overflow_d = acc_ovf_inc;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    osc_en_d = (state_d == SETTLE) || (state_d == MEASURE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      acc_ovf_q    <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      osc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      acc_q        <= acc_d;
      acc_ovf_q    <= acc_ovf_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      osc_en_q     <= osc_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign osc_en   = osc_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ringosc_meter.sv
// tb/tb_ringosc_meter.sv - directed self-checking bench for ringosc_meter
module tb_ringosc_meter;

  localparam int CNT_W  = 4;
  localparam int GATE_W = 16;
  localparam int SETTLE = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [GATE_W-1:0] gate_cycles = '0;
  logic              osc_in = 1'b0;
  logic              osc_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  int passed = 0;
  int total  = 0;

  int osc_period = 8;
  bit osc_dead   = 1'b0;
  int osc_ph     = 0;

  ringosc_meter #(
    .CNT_W      (CNT_W),
    .GATE_W     (GATE_W),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gate_cycles (gate_cycles),
    .osc_in      (osc_in),
    .osc_en      (osc_en),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    osc_ph = (osc_ph + 1) % osc_period;
    osc_in = osc_dead ? 1'b1 : (osc_ph < osc_period / 2);
  end

  // Runs one measurement; cycle n is the n-th cycle after the one where start is sampled.
  task automatic do_run(input int g, input int poke_n, input int poke_g,
                        output int lat, output int pulses, output int prof_err,
                        output logic [CNT_W-1:0] cnt, output logic ovf);
    int limit;
    limit    = SETTLE + g + 6;
    lat      = -1;
    pulses   = 0;
    prof_err = 0;
    cnt      = '0;
    ovf      = 1'b0;
    @(negedge clk);
    gate_cycles = GATE_W'(g);
    start       = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          cnt = count;
          ovf = overflow;
        end
      end
      if (osc_en !== (n <= SETTLE + g))     prof_err++;
      if (busy   !== (n <= SETTLE + g + 1)) prof_err++;
      if (done   !== (n == SETTLE + g + 1)) prof_err++;
      if (n == poke_n) begin
        start       = 1'b1;
        gate_cycles = GATE_W'(poke_g);
      end else begin
        start       = 1'b0;
        gate_cycles = GATE_W'(3);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (osc_en !== 1'b0)   $display("FAIL reset_osc_en: got %b want 0", osc_en); else passed++;
    total++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0)     $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (count !== 4'd0)    $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int lat, pulses, perr;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    osc_period = 8;
    repeat (4) @(negedge clk);
    do_run(64, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (lat !== 73)     $display("FAIL nominal_latency: got %0d want 73", lat); else passed++;
    total++; if (pulses !== 1)   $display("FAIL nominal_done_pulses: got %0d want 1", pulses); else passed++;
    total++; if (cnt !== 4'd8)   $display("FAIL nominal_count: got %0d want 8", cnt); else passed++;
    total++; if (ovf !== 1'b0)   $display("FAIL nominal_overflow: got %b want 0", ovf); else passed++;
    total++; if (perr !== 0)     $display("FAIL nominal_profile: got %0d errors want 0", perr); else passed++;
    total++; if (count !== 4'd8) $display("FAIL nominal_count_held: got %0d want 8", count); else passed++;
  endtask

  task automatic test_zero_gate();
    int lat, pulses, perr;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    do_run(0, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (lat !== SETTLE + 1) $display("FAIL zero_latency: got %0d want %0d", lat, SETTLE + 1); else passed++;
    total++; if (cnt !== 4'd0)       $display("FAIL zero_count: got %0d want 0", cnt); else passed++;
    total++; if (ovf !== 1'b0)       $display("FAIL zero_overflow: got %b want 0", ovf); else passed++;
    total++; if (perr !== 0)         $display("FAIL zero_osc_en_profile: got %0d errors want 0", perr); else passed++;
  endtask

  task automatic test_saturation();
    int lat, pulses, perr;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    osc_period = 4;
    repeat (4) @(negedge clk);
    do_run(100, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (lat !== 109)   $display("FAIL sat_latency: got %0d want 109", lat); else passed++;
    total++; if (cnt !== 4'd15) $display("FAIL sat_count: got %0d want 15", cnt); else passed++;
    total++; if (ovf !== 1'b1)  $display("FAIL sat_overflow: got %b want 1", ovf); else passed++;
    do_run(16, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (cnt !== 4'd4)  $display("FAIL sat_next_count: got %0d want 4", cnt); else passed++;
    total++; if (ovf !== 1'b0)  $display("FAIL sat_next_overflow: got %b want 0", ovf); else passed++;
  endtask

  task automatic test_busy_start();
    int lat, pulses, perr;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    osc_period = 8;
    repeat (4) @(negedge clk);
    do_run(64, 20, 5, lat, pulses, perr, cnt, ovf);
    total++; if (lat !== 73)   $display("FAIL busy_start_latency: got %0d want 73", lat); else passed++;
    total++; if (pulses !== 1) $display("FAIL busy_start_done_pulses: got %0d want 1", pulses); else passed++;
    total++; if (cnt !== 4'd8) $display("FAIL busy_start_count: got %0d want 8", cnt); else passed++;
    total++; if (perr !== 0)   $display("FAIL busy_start_profile: got %0d errors want 0", perr); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses, perr, stray;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    osc_period = 4;
    repeat (4) @(negedge clk);
    do_run(100, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (overflow !== 1'b1) $display("FAIL midrst_pre_overflow: got %b want 1", overflow); else passed++;
    @(negedge clk);
    gate_cycles = GATE_W'(64);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (osc_en !== 1'b0)   $display("FAIL midrst_osc_en: got %b want 0", osc_en); else passed++;
    total++; if (busy !== 1'b0)     $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0)     $display("FAIL midrst_done: got %b want 0", done); else passed++;
    total++; if (count !== 4'd0)    $display("FAIL midrst_count: got %0d want 0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", overflow); else passed++;
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    total++; if (stray !== 0) $display("FAIL midrst_no_done: got %0d active cycles want 0", stray); else passed++;
    osc_period = 8;
    repeat (4) @(negedge clk);
    do_run(64, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (lat !== 73)   $display("FAIL midrst_fresh_latency: got %0d want 73", lat); else passed++;
    total++; if (cnt !== 4'd8) $display("FAIL midrst_fresh_count: got %0d want 8", cnt); else passed++;
  endtask

  task automatic test_dead_ring();
    int lat, pulses, perr;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    osc_dead = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (osc_en !== 1'b0) $display("FAIL dead_idle_osc_en: got %b want 0", osc_en); else passed++;
    do_run(64, 0, 0, lat, pulses, perr, cnt, ovf);
    total++; if (cnt !== 4'd0)    $display("FAIL dead_count: got %0d want 0", cnt); else passed++;
    total++; if (ovf !== 1'b0)    $display("FAIL dead_overflow: got %b want 0", ovf); else passed++;
    total++; if (perr !== 0)      $display("FAIL dead_profile: got %0d errors want 0", perr); else passed++;
    total++; if (osc_en !== 1'b0) $display("FAIL dead_after_osc_en: got %b want 0", osc_en); else passed++;
    osc_dead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_gate();
    test_saturation();
    test_busy_start();
    test_reset_mid_run();
    test_dead_ring();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
